// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock first-word-fall-through FIFO with registered
// full/empty flags and an occupancy count.
`default_nettype none

module sync_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  signal_write,
   input  logic                  signal_read,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wptr;
   logic [ADDR_WIDTH:0]   rptr;
   logic [ADDR_WIDTH:0]   wptr_next;
   logic [ADDR_WIDTH:0]   rptr_next;
   logic                  wr_en;
   logic                  rd_en;

   // Requests are qualified against the flags as they stood before the edge.
   always_comb begin
      wr_en     = signal_write & ~full;
      rd_en     = signal_read & ~empty;
      wptr_next = wptr + {{ADDR_WIDTH{1'b0}}, wr_en};
      rptr_next = rptr + {{ADDR_WIDTH{1'b0}}, rd_en};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         wptr  <= wptr_next;
         rptr  <= rptr_next;
         empty <= (wptr_next == rptr_next);
         full  <= (wptr_next[ADDR_WIDTH] != rptr_next[ADDR_WIDTH]) &&
                  (wptr_next[ADDR_WIDTH-1:0] == rptr_next[ADDR_WIDTH-1:0]);
      end
   end

   for (genvar w = 0; w < DEPTH; w++) begin : g_mem
      always_ff @(posedge clk) begin
         if (rst) begin
            mem[w] <= '0;
         end else if (wr_en && (wptr[ADDR_WIDTH-1:0] == ADDR_WIDTH'(w))) begin
            mem[w] <= write_data;
         end
      end
   end

   assign read_data = mem[rptr[ADDR_WIDTH-1:0]];
   assign count     = wptr - rptr;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed and randomized checks of sync_fifo_ctrl against
// a queue-based reference model.
`default_nettype none

module tb_sync_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] write_data = '0;
   logic       signal_write = 1'b0;
   logic       signal_read = 1'b0;
   logic [7:0] read_data;
   logic       full;
   logic       empty;
   logic [3:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q[$];

   sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .write_data   (write_data),
      .signal_write (signal_write),
      .signal_read  (signal_read),
      .read_data    (read_data),
      .full         (full),
      .empty        (empty),
      .count        (count)
   );

   always #5 clk = ~clk;

   // One clock edge with the given requests; the model follows the FIFO rules.
   task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic rs);
      logic w_ok;
      logic r_ok;
      rst          = rs;
      signal_write = w;
      signal_read  = r;
      write_data   = d;
      @(posedge clk);
      if (rs) begin
         q.delete();
      end else begin
         w_ok = w && (q.size() < 8);
         r_ok = r && (q.size() > 0);
         if (r_ok) void'(q.pop_front());
         if (w_ok) q.push_back(d);
      end
      #1;
      rst          = 1'b0;
      signal_write = 1'b0;
      signal_read  = 1'b0;
   endtask

   task automatic test_reset();
      drive(0, 0, 8'h00, 1);
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
      n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL reset_read_data: got %h want 00", read_data); end
      drive(0, 1, 8'h00, 0);
      n_checks++; if (empty !== 1'b1 || count !== 4'd0 || read_data !== 8'h00) begin
         n_fail++; $display("FAIL read_when_empty: empty=%b count=%0d data=%h want 1/0/00", empty, count, read_data);
      end
   endtask

   task automatic test_single();
      drive(1, 0, 8'd1, 0);
      n_checks++; if (empty !== 1'b0 || count !== 4'd1 || read_data !== 8'd1) begin
         n_fail++; $display("FAIL single_write: empty=%b count=%0d data=%0d want 0/1/1", empty, count, read_data);
      end
      drive(0, 1, 8'd0, 0);
      n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin
         n_fail++; $display("FAIL single_read: empty=%b count=%0d want 1/0", empty, count);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] expect_pop;
      expect_pop = 8'd2;
      drive(1, 0, 8'd2, 0);
      drive(1, 0, 8'd3, 0);
      for (int k = 0; k < 9; k++) begin
         drive(1, 0, 8'(k + 4), 0);
         n_checks++; if (read_data !== expect_pop) begin
            n_fail++; $display("FAIL wrap_order[%0d]: got %0d want %0d", k, read_data, expect_pop);
         end
         drive(0, 1, 8'd0, 0);
         expect_pop++;
      end
      n_checks++; if (count !== 4'd2 || read_data !== 8'd11) begin
         n_fail++; $display("FAIL wrap_tail: count=%0d data=%0d want 2/11", count, read_data);
      end
      drive(0, 1, 8'd0, 0);
      drive(0, 1, 8'd0, 0);
   endtask

   task automatic test_fill_full();
      for (int k = 0; k < 8; k++) begin
         n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_early[%0d]: got %b want 0", k, full); end
         drive(1, 0, 8'(24 + k), 0);
      end
      n_checks++; if (full !== 1'b1 || count !== 4'd8) begin
         n_fail++; $display("FAIL full_set: full=%b count=%0d want 1/8", full, count);
      end
      drive(1, 0, 8'd99, 0);
      n_checks++; if (full !== 1'b1 || count !== 4'd8 || read_data !== 8'd24) begin
         n_fail++; $display("FAIL write_when_full: full=%b count=%0d data=%0d want 1/8/24", full, count, read_data);
      end
      for (int k = 0; k < 8; k++) begin
         n_checks++; if (read_data !== 8'(24 + k)) begin
            n_fail++; $display("FAIL drain[%0d]: got %0d want %0d", k, read_data, 24 + k);
         end
         drive(0, 1, 8'd0, 0);
      end
      n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin
         n_fail++; $display("FAIL drain_empty: empty=%b count=%0d want 1/0", empty, count);
      end
   endtask

   task automatic test_simultaneous();
      drive(1, 1, 8'd5, 0);
      n_checks++; if (count !== 4'd1 || read_data !== 8'd5) begin
         n_fail++; $display("FAIL both_empty: count=%0d data=%0d want 1/5", count, read_data);
      end
      for (int k = 0; k < 7; k++) drive(1, 0, 8'(10 + k), 0);
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL both_prefill: full=%b want 1", full); end
      drive(1, 1, 8'd77, 0);
      n_checks++; if (count !== 4'd7 || full !== 1'b0 || read_data !== 8'd10) begin
         n_fail++; $display("FAIL both_full: count=%0d full=%b data=%0d want 7/0/10", count, full, read_data);
      end
      drive(1, 1, 8'd88, 0);
      n_checks++; if (count !== 4'd7 || full !== 1'b0 || empty !== 1'b0 || read_data !== 8'd11) begin
         n_fail++; $display("FAIL both_mid: count=%0d full=%b empty=%b data=%0d want 7/0/0/11", count, full, empty, read_data);
      end
      for (int k = 0; k < 7; k++) drive(0, 1, 8'd0, 0);
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 5; k++) drive(1, 0, 8'(40 + k), 0);
      n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL mid_prefill: count=%0d want 5", count); end
      drive(1, 0, 8'd55, 1);
      n_checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || read_data !== 8'd0) begin
         n_fail++; $display("FAIL reset_mid: count=%0d empty=%b full=%b data=%0d want 0/1/0/0", count, empty, full, read_data);
      end
      drive(0, 0, 8'd0, 0);
      n_checks++; if (count !== 4'd0 || read_data !== 8'd0) begin
         n_fail++; $display("FAIL reset_mid_discard: count=%0d data=%0d want 0/0", count, read_data);
      end
   endtask

   task automatic test_random();
      logic w;
      logic r;
      logic rs;
      for (int i = 0; i < 600; i++) begin
         w  = 1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
         r  = 1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
         rs = ($urandom_range(0, 149) == 0);
         drive(w, r, 8'($urandom), rs);
         n_checks++; if (count !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == 8)) begin
            n_fail++; $display("FAIL rand_flags[%0d]: count=%0d empty=%b full=%b want count %0d", i, count, empty, full, q.size());
         end
         if (q.size() > 0) begin
            n_checks++; if (read_data !== q[0]) begin
               n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, read_data, q[0]);
            end
         end else if (rs) begin
            n_checks++; if (read_data !== 8'h00) begin
               n_fail++; $display("FAIL rand_reset_data[%0d]: got %h want 00", i, read_data);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_fill_full();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
